tour_move_sequencer: RTL

- Sits between the tour solver and the command processor inside the KnightsTour top.
- Once the solver finishes, it reads the one-hot move list one entry at a time and splits each knight move into two commands: a vertical leg, then a horizontal leg with fanfare.
- It drives the command processor in place of the UART command path while the tour runs.
- It supplies the response byte the top returns over UART after each leg: 0x5A for intermediate legs, 0xA5 after the final leg.

---
 rtl/tour_move_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/tour_move_sequencer.sv
// rtl/tour_move_sequencer.sv - splits each one-hot knight move into vertical and horizontal leg commands
module tour_move_sequencer #(
  parameter int NUM_MOVES = 24,
  parameter int IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_tour,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic             tour_active,
  output logic [7:0]       resp,
  output logic             tour_err
);

  typedef enum logic [2:0] {IDLE, VERT, VWAIT, HORZ, HWAIT} state_t;

  localparam logic [3:0] OP_MOVE     = 4'b0010;
  localparam logic [3:0] OP_FANFARE  = 4'b0011;
  localparam logic [7:0] HDG_N       = 8'h00;
  localparam logic [7:0] HDG_W       = 8'h3F;
  localparam logic [7:0] HDG_S       = 8'h7F;
  localparam logic [7:0] HDG_E       = 8'hBF;
  localparam logic [7:0] RESP_MID    = 8'h5A;
  localparam logic [7:0] RESP_DONE   = 8'hA5;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MOVES - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] mv_indx_d;
  logic [15:0]      cmd_d;
  logic             cmd_rdy_d;
  logic             tour_active_d;
  logic [7:0]       resp_d;
  logic             tour_err_d;
  logic [15:0]      hcmd_q, hcmd_d;

  // Move decode: legal moves map to a (vertical, horizontal) command pair;
  // anything that is not exactly one-hot is flagged as illegal.
  logic        move_ok;
  logic [15:0] vert_cmd;
  logic [15:0] horz_cmd;

  // Decode the current move into its two leg commands
  always_comb begin
    move_ok  = 1'b1;
    vert_cmd = 16'h0000;
    horz_cmd = 16'h0000;
    case (move)
      8'h01: begin vert_cmd = {OP_MOVE, HDG_N, 4'd2}; horz_cmd = {OP_FANFARE, HDG_E, 4'd1}; end
      8'h02: begin vert_cmd = {OP_MOVE, HDG_N, 4'd2}; horz_cmd = {OP_FANFARE, HDG_W, 4'd1}; end
      8'h04: begin vert_cmd = {OP_MOVE, HDG_N, 4'd1}; horz_cmd = {OP_FANFARE, HDG_W, 4'd2}; end
      8'h08: begin vert_cmd = {OP_MOVE, HDG_S, 4'd1}; horz_cmd = {OP_FANFARE, HDG_W, 4'd2}; end
      8'h10: begin vert_cmd = {OP_MOVE, HDG_S, 4'd2}; horz_cmd = {OP_FANFARE, HDG_W, 4'd1}; end
      8'h20: begin vert_cmd = {OP_MOVE, HDG_S, 4'd2}; horz_cmd = {OP_FANFARE, HDG_E, 4'd1}; end
      8'h40: begin vert_cmd = {OP_MOVE, HDG_S, 4'd1}; horz_cmd = {OP_FANFARE, HDG_E, 4'd2}; end
      8'h80: begin vert_cmd = {OP_MOVE, HDG_N, 4'd1}; horz_cmd = {OP_FANFARE, HDG_E, 4'd2}; end
      default: move_ok = 1'b0;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mv_indx     <= '0;
      cmd         <= 16'h0000;
      cmd_rdy     <= 1'b0;
      tour_active <= 1'b0;
      resp        <= RESP_DONE;
      tour_err    <= 1'b0;
      hcmd_q      <= 16'h0000;
    end else begin
      state_q     <= state_d;
      mv_indx     <= mv_indx_d;
      cmd         <= cmd_d;
      cmd_rdy     <= cmd_rdy_d;
      tour_active <= tour_active_d;
      resp        <= resp_d;
      tour_err    <= tour_err_d;
      hcmd_q      <= hcmd_d;
    end
  end

  // Next-state and next-output logic; registers hold unless a state acts
  always_comb begin
    state_d       = state_q;
    mv_indx_d     = mv_indx;
    cmd_d         = cmd;
    cmd_rdy_d     = cmd_rdy;
    tour_active_d = tour_active;
    resp_d        = resp;
    tour_err_d    = 1'b0;
    hcmd_d        = hcmd_q;

    case (state_q)
      IDLE: begin
        if (start_tour) begin
          mv_indx_d     = '0;
          tour_active_d = 1'b1;
          state_d       = VERT;
        end
      end

      VERT: begin
        if (!move_ok) begin
          tour_err_d    = 1'b1;
          tour_active_d = 1'b0;
          state_d       = IDLE;
        end else begin
          cmd_d     = vert_cmd;
          hcmd_d    = horz_cmd;
          cmd_rdy_d = 1'b1;
          state_d   = VWAIT;
        end
      end

      VWAIT: begin
        if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
        if (send_resp) begin
          resp_d  = RESP_MID;
          state_d = HORZ;
        end
      end

      HORZ: begin
        // Horizontal leg was captured alongside the vertical one so a
        // solver memory change mid-move cannot split the knight move.
        cmd_d     = hcmd_q;
        cmd_rdy_d = 1'b1;
        state_d   = HWAIT;
      end

      HWAIT: begin
        if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
        if (send_resp) begin
          if (mv_indx == LAST_IDX) begin
            resp_d        = RESP_DONE;
            tour_active_d = 1'b0;
            state_d       = IDLE;
          end else begin
            resp_d    = RESP_MID;
            mv_indx_d = mv_indx + IDX_W'(1);
            state_d   = VERT;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
